// File: rtl/wb_arb_rr2.sv
// Two-master to one-slave round-robin Wishbone-style arbiter, one whole transaction per grant.
// Latency: s_cyc rises one cycle after a request; acks pass through combinationally during a grant.
// Backpressure: the losing master waits with cyc held; an IDLE cycle always separates two grants.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   m0_*, m1_*          master ports (addr, wdata, we, cyc in; rdata, ack out)
//   s_*                 slave port (addr, wdata, we, cyc out; rdata, ack in)
//   err                 one-cycle pulse when a grant is ended by the ack timeout
//
// Optional feature: define WB_ARB_RR2_TIMEOUT_EN to end a grant with a synthetic ack
// (rdata all ones, err pulse) after TIMEOUT cycles without a slave ack. Without it err is 0
// and a hung slave keeps the grant until the master drops cyc.
module wb_arb_rr2 #(
    parameter int AW      = 9,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,

    input  logic [AW-1:0] m0_addr,
    output logic [DW-1:0] m0_rdata,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_we,
    input  logic          m0_cyc,
    output logic          m0_ack,

    input  logic [AW-1:0] m1_addr,
    output logic [DW-1:0] m1_rdata,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_we,
    input  logic          m1_cyc,
    output logic          m1_ack,

    output logic [AW-1:0] s_addr,
    input  logic [DW-1:0] s_rdata,
    output logic [DW-1:0] s_wdata,
    output logic          s_we,
    output logic          s_cyc,
    input  logic          s_ack,

    output logic          err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t state;
    logic   last;      // master that completed the most recent grant
    logic   gnt0;
    logic   gnt1;
    logic   cur_cyc;   // cyc of the master currently holding the grant
    logic   to_hit;    // timeout fires this cycle (never without the feature)

    assign gnt0    = (state == G0);
    assign gnt1    = (state == G1);
    assign cur_cyc = (gnt0 & m0_cyc) | (gnt1 & m1_cyc);

`ifdef WB_ARB_RR2_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] to_cnt;

    // A real ack in the same cycle wins over the timeout; a master that already
    // dropped cyc is treated as an abort, not handed a synthetic ack.
    assign to_hit = cur_cyc & ~s_ack & (to_cnt == CW'(TIMEOUT));
    assign err    = to_hit;

    // Cleared while idle so it starts from zero on grant entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state == IDLE) begin
            to_cnt <= '0;
        end else if (!s_ack) begin
            to_cnt <= to_cnt + CW'(1);
        end
    end
`else
    localparam int unsigned unused_timeout = TIMEOUT;

    assign to_hit = 1'b0;
    assign err    = 1'b0;
`endif

    // Slave side: master 0 is steered through whenever master 1 is not granted,
    // so the slave sees stable (ignored) values while idle.
    assign s_addr  = gnt1 ? m1_addr  : m0_addr;
    assign s_wdata = gnt1 ? m1_wdata : m0_wdata;
    assign s_we    = gnt1 ? m1_we    : m0_we;
    assign s_cyc   = cur_cyc & ~to_hit;

    // Read data is broadcast; it only matters alongside the owner's ack.
    assign m0_rdata = (gnt0 & to_hit) ? {DW{1'b1}} : s_rdata;
    assign m1_rdata = (gnt1 & to_hit) ? {DW{1'b1}} : s_rdata;
    assign m0_ack   = gnt0 & (s_ack | to_hit);
    assign m1_ack   = gnt1 & (s_ack | to_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;     // master 0 wins the first tie
        end else begin
            case (state)
                IDLE: begin
                    // On a tie the master that did not complete last wins.
                    if (m0_cyc && (!m1_cyc || last)) begin
                        state <= G0;
                    end else if (m1_cyc) begin
                        state <= G1;
                    end
                end
                G0, G1: begin
                    if (s_ack || to_hit) begin
                        state <= IDLE;
                        last  <= (state == G1);
                    end else if (!cur_cyc) begin
                        // Abort: release the slave, fairness history untouched.
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arb_rr2.sv
module tb_wb_arb_rr2;

    logic        clk;
    logic        rst;
    logic [8:0]  m0_addr, m1_addr, s_addr;
    logic [31:0] m0_rdata, m1_rdata, m0_wdata, m1_wdata, s_rdata, s_wdata;
    logic        m0_we, m1_we, s_we;
    logic        m0_cyc, m1_cyc, s_cyc;
    logic        m0_ack, m1_ack, s_ack;
    logic        err;

    logic        slv_ack;
    logic        spur_ack;
    int          slv_lat;
    bit          slv_hang;
    int          slv_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         n0;
        int         n1;
        logic [8:0] a0;
        logic [8:0] a1;
        bit         we0;
        bit         we1;
        logic [31:0] d0;
        logic [31:0] d1;
        int         lat;
    } vec_t;

    typedef struct {
        logic [8:0]  addr;
        bit          we;
        logic [31:0] dat;
    } job_t;

    typedef struct {
        int          id;
        logic [8:0]  addr;
        bit          we;
        logic [31:0] dat;
    } exp_t;

    job_t jobs0[$];
    job_t jobs1[$];
    exp_t exp_q[$];
    bit   last_m;
    bit   gap_pend;

    wb_arb_rr2 #(.AW(9), .DW(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_rdata(m0_rdata), .m0_wdata(m0_wdata),
        .m0_we(m0_we), .m0_cyc(m0_cyc), .m0_ack(m0_ack),
        .m1_addr(m1_addr), .m1_rdata(m1_rdata), .m1_wdata(m1_wdata),
        .m1_we(m1_we), .m1_cyc(m1_cyc), .m1_ack(m1_ack),
        .s_addr(s_addr), .s_rdata(s_rdata), .s_wdata(s_wdata),
        .s_we(s_we), .s_cyc(s_cyc), .s_ack(s_ack),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign s_ack = slv_ack | spur_ack;

    function automatic logic [31:0] rd_fn(input logic [8:0] a);
        return (a == 9'h012) ? 32'hCAFEF00D : {16'hA5C3, 7'd0, a};
    endfunction

    // Slave model: acks slv_lat cycles after it first sees s_cyc, one-cycle pulse.
    initial begin
        slv_ack = 1'b0;
        s_rdata = 32'h0;
        slv_cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                slv_ack = 1'b0;
                slv_cnt = 0;
            end else if (slv_ack) begin
                slv_ack = 1'b0;
                slv_cnt = 0;
            end else if (s_cyc && !slv_hang) begin
                slv_cnt++;
                if (slv_cnt > slv_lat) begin
                    slv_ack = 1'b1;
                    s_rdata = rd_fn(s_addr);
                end else begin
                    s_rdata = $urandom();
                end
            end else begin
                slv_cnt = 0;
                s_rdata = $urandom();
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nxt();
        rst = 1'b1;
        m0_cyc = 1'b0;
        m1_cyc = 1'b0;
        spur_ack = 1'b0;
        slv_hang = 1'b0;
        nxt();
        nxt();
        rst = 1'b0;
        last_m = 1'b1;
        gap_pend = 1'b0;
        jobs0.delete();
        jobs1.delete();
        exp_q.delete();
    endtask

    // One clock of the scoreboarded traffic: check acks at negedge, advance masters after posedge.
    task automatic cycle();
        logic a0, a1;
        exp_t e;
        job_t j;
        @(negedge clk);
        if (gap_pend) begin
            chk("gap_scyc", 32'(s_cyc), 32'd0);
            gap_pend = 1'b0;
        end
        a0 = m0_ack;
        a1 = m1_ack;
        if (a0 | a1) begin
            gap_pend = 1'b1;
            chk("single_ack", 32'(a0 & a1), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: m0_ack=%b m1_ack=%b with nothing expected", a0, a1);
            end else begin
                e = exp_q.pop_front();
                chk("grant_id", a1 ? 32'd1 : 32'd0, 32'(e.id));
                chk("s_addr", 32'(s_addr), 32'(e.addr));
                chk("s_we", 32'(s_we), 32'(e.we));
                if (e.we) chk("s_wdata", s_wdata, e.dat);
                else      chk("rdata", a1 ? m1_rdata : m0_rdata, e.dat);
            end
        end
        nxt();
        if (a0 || (!m0_cyc && jobs0.size() > 0)) begin
            if (jobs0.size() > 0) begin
                j = jobs0.pop_front();
                m0_cyc = 1'b1; m0_addr = j.addr; m0_we = j.we; m0_wdata = j.dat;
            end else begin
                m0_cyc = 1'b0;
            end
        end
        if (a1 || (!m1_cyc && jobs1.size() > 0)) begin
            if (jobs1.size() > 0) begin
                j = jobs1.pop_front();
                m1_cyc = 1'b1; m1_addr = j.addr; m1_we = j.we; m1_wdata = j.dat;
            end else begin
                m1_cyc = 1'b0;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int r0, r1, i0, i1, pick, c;
        logic [8:0] a;
        slv_lat = v.lat;
        slv_hang = 1'b0;
        for (int k = 0; k < v.n0; k++)
            jobs0.push_back('{v.a0 + 9'(k), v.we0, v.d0 + 32'(k)});
        for (int k = 0; k < v.n1; k++)
            jobs1.push_back('{v.a1 + 9'(k), v.we1, v.d1 + 32'(k)});
        // Expected order: alternate while both still have work, tie goes to the non-last master.
        r0 = v.n0; r1 = v.n1; i0 = 0; i1 = 0;
        while (r0 > 0 || r1 > 0) begin
            if (r0 > 0 && r1 > 0) pick = last_m ? 0 : 1;
            else                  pick = (r0 > 0) ? 0 : 1;
            if (pick == 0) begin
                a = v.a0 + 9'(i0);
                exp_q.push_back('{0, a, v.we0, v.we0 ? v.d0 + 32'(i0) : rd_fn(a)});
                i0++; r0--;
            end else begin
                a = v.a1 + 9'(i1);
                exp_q.push_back('{1, a, v.we1, v.we1 ? v.d1 + 32'(i1) : rd_fn(a)});
                i1++; r1--;
            end
            last_m = (pick == 1);
        end
        c = 0;
        while (c < 500 && (exp_q.size() > 0 || m0_cyc || m1_cyc ||
                           jobs0.size() > 0 || jobs1.size() > 0)) begin
            cycle();
            c++;
        end
        chk("round_drained", 32'(exp_q.size()), 32'd0);
        cycle();
        cycle();
    endtask

    task automatic wait_ack(input int id, input string name);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if ((id == 0) ? m0_ack : m1_ack) begin
                got = 1'b1;
                break;
            end
            nxt();
        end
        chk(name, 32'(got), 32'd1);
        nxt();
        if (id == 0) m0_cyc = 1'b0;
        else         m1_cyc = 1'b0;
    endtask

    vec_t tbl[6];
    bit   seen_ack, seen_err;

    initial begin
        rst = 1'b1;
        m0_cyc = 1'b0; m1_cyc = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        spur_ack = 1'b0; slv_lat = 2; slv_hang = 1'b0;
        last_m = 1'b1; gap_pend = 1'b0;

        tbl[0] = '{1, 1, 9'h012, 9'h100, 1'b0, 1'b0, 32'h0,        32'h0,        2};
        tbl[1] = '{4, 4, 9'h020, 9'h1F0, 1'b0, 1'b1, 32'h0,        32'h11110000, 1};
        tbl[2] = '{4, 2, 9'h080, 9'h140, 1'b1, 1'b1, 32'hD0A00000, 32'hC0000000, 0};
        tbl[3] = '{0, 3, 9'h000, 9'h1A0, 1'b0, 1'b0, 32'h0,        32'h0,        3};
        tbl[4] = '{2, 0, 9'h0F0, 9'h000, 1'b1, 1'b0, 32'h5A5A0000, 32'h0,        1};
        tbl[5] = '{1, 1, 9'h012, 9'h013, 1'b0, 1'b0, 32'h0,        32'h0,        2};

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_scyc", 32'(s_cyc), 32'd0);
        chk("rst_m0_ack", 32'(m0_ack), 32'd0);
        chk("rst_m1_ack", 32'(m1_ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Single read, slave acks 2 cycles after s_cyc
        slv_lat = 2;
        nxt();
        m0_cyc = 1'b1; m0_addr = 9'h012; m0_we = 1'b0;
        @(negedge clk); chk("sr_scyc_arb", 32'(s_cyc), 32'd0);
        nxt();
        @(negedge clk); chk("sr_scyc", 32'(s_cyc), 32'd1);
        chk("sr_addr", 32'(s_addr), 32'h012);
        nxt();
        @(negedge clk); chk("sr_ack_early", 32'(m0_ack), 32'd0);
        nxt();
        @(negedge clk); chk("sr_ack", 32'(m0_ack), 32'd1);
        chk("sr_rdata", m0_rdata, 32'hCAFEF00D);
        chk("sr_m1_ack", 32'(m1_ack), 32'd0);
        nxt();
        m0_cyc = 1'b0;
        @(negedge clk); chk("sr_ack_once", 32'(m0_ack), 32'd0);
        chk("sr_scyc_drop", 32'(s_cyc), 32'd0);

        // Spurious slave ack while idle
        nxt();
        spur_ack = 1'b1;
        @(negedge clk); chk("spur_m0_ack", 32'(m0_ack), 32'd0);
        chk("spur_m1_ack", 32'(m1_ack), 32'd0);
        nxt();
        spur_ack = 1'b0;
        @(negedge clk); chk("spur_scyc", 32'(s_cyc), 32'd0);

        // Table-driven scoreboarded rounds
        do_reset();
        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // Abort: m1 granted, m0 pending, m1 drops cyc
        do_reset();
        slv_hang = 1'b1;
        nxt();
        m1_cyc = 1'b1; m1_addr = 9'h0AB; m1_we = 1'b1; m1_wdata = 32'h12345678;
        @(negedge clk); chk("ab_idle0", 32'(s_cyc), 32'd0);
        nxt();
        m0_cyc = 1'b1; m0_addr = 9'h055; m0_we = 1'b0;
        @(negedge clk); chk("ab_g1_scyc", 32'(s_cyc), 32'd1);
        chk("ab_g1_addr", 32'(s_addr), 32'h0AB);
        nxt();
        m1_cyc = 1'b0;
        @(negedge clk); chk("ab_drop", 32'(s_cyc), 32'd0);
        chk("ab_m1_ack", 32'(m1_ack), 32'd0);
        nxt();
        m1_cyc = 1'b1;
        @(negedge clk); chk("ab_idle1", 32'(s_cyc), 32'd0);
        nxt();
        @(negedge clk); chk("ab_m0_scyc", 32'(s_cyc), 32'd1);
        chk("ab_m0_addr", 32'(s_addr), 32'h055);
        slv_hang = 1'b0; slv_lat = 1;
        wait_ack(0, "ab_m0_done");
        wait_ack(1, "ab_m1_done");
        // last is now 1; make it 0, then abort m1 and confirm last was kept
        nxt();
        m0_cyc = 1'b1; m0_addr = 9'h011; m0_we = 1'b0;
        wait_ack(0, "ab_m0_single");
        slv_hang = 1'b1;
        nxt();
        m1_cyc = 1'b1; m1_addr = 9'h0CC;
        @(negedge clk);
        nxt();
        @(negedge clk); chk("ab2_g1_addr", 32'(s_addr), 32'h0CC);
        nxt();
        m1_cyc = 1'b0;
        @(negedge clk); chk("ab2_drop", 32'(s_cyc), 32'd0);
        nxt();
        m0_cyc = 1'b1; m0_addr = 9'h044; m1_cyc = 1'b1;
        @(negedge clk); chk("ab2_idle", 32'(s_cyc), 32'd0);
        nxt();
        @(negedge clk); chk("ab2_last_kept", 32'(s_addr), 32'h0CC);

        // Reset in the middle of a grant
        do_reset();
        slv_hang = 1'b1;
        nxt();
        m0_cyc = 1'b1; m0_addr = 9'h077; m0_we = 1'b0;
        @(negedge clk);
        nxt();
        @(negedge clk); chk("rm_scyc", 32'(s_cyc), 32'd1);
        nxt();
        rst = 1'b1; slv_hang = 1'b0; slv_lat = 0;
        @(negedge clk); chk("rm_sync", 32'(s_cyc), 32'd1);
        nxt();
        rst = 1'b0;
        @(negedge clk); chk("rm_scyc_low", 32'(s_cyc), 32'd0);
        chk("rm_ack_lost", 32'(m0_ack), 32'd0);

        // Hung slave
        do_reset();
        slv_hang = 1'b1;
        nxt();
        m0_cyc = 1'b1; m0_addr = 9'h033; m0_we = 1'b0;
`ifdef WB_ARB_RR2_TIMEOUT_EN
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("to_ack", 32'(m0_ack), (k == 17) ? 32'd1 : 32'd0);
            chk("to_err", 32'(err), (k == 17) ? 32'd1 : 32'd0);
            if (k == 17) begin
                chk("to_rdata", m0_rdata, 32'hFFFFFFFF);
                chk("to_scyc", 32'(s_cyc), 32'd0);
            end
            nxt();
            if (k == 17) m0_cyc = 1'b0;
        end
`else
        seen_ack = 1'b0;
        seen_err = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (m0_ack) seen_ack = 1'b1;
            if (err)    seen_err = 1'b1;
            nxt();
        end
        chk("hang_no_ack", 32'(seen_ack), 32'd0);
        chk("hang_no_err", 32'(seen_err), 32'd0);
        @(negedge clk); chk("hang_held", 32'(s_cyc), 32'd1);
        nxt();
        m0_cyc = 1'b0;
        @(negedge clk); chk("hang_release", 32'(s_cyc), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_arb_rr2.md
Name: wb_arb_rr2

Overview:
- Two-master to one-slave round-robin arbiter on the team's lightweight Wishbone-style bus (addr/rdata/wdata/we/cyc/ack).
- Sits directly downstream of a wb_dma master port (typically m1). Lets the DMA share a single-ported buffer (E1 frame SPRAM) with a second master, usually the CPU bridge.
- Grants one complete transaction at a time. Each grant ends on slave ack or master abort.

Parameters:
AW, 9, address width of masters and slave
DW, 32, data width
TIMEOUT, 255, slave ack timeout in cycles (used only with WB_ARB_RR2_TIMEOUT_EN; TIMEOUT ≥ 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m0_addr  in  AW  master 0 address
m0_rdata  out  DW  master 0 read data
m0_wdata  in  DW  master 0 write data
m0_we  in  1  master 0 write enable
m0_cyc  in  1  master 0 cycle request
m0_ack  out  1  master 0 acknowledge
m1_addr/m1_rdata/m1_wdata/m1_we/m1_cyc/m1_ack  same as m0, for master 1
s_addr  out  AW  slave address
s_rdata  in  DW  slave read data
s_wdata  out  DW  slave write data
s_we  out  1  slave write enable
s_cyc  out  1  slave cycle
s_ack  in  1  slave acknowledge (one-cycle pulse)
err  out  1  timeout pulse (constant 0 without WB_ARB_RR2_TIMEOUT_EN)

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is synchronous and active-high.
- State machine: IDLE, G0, G1. State and a `last` bit are registered.
- Reset values: state=IDLE, last=1 so master 0 wins the first tie, timeout counter=0, err=0. Consequently s_cyc=0 and m0_ack=m1_ack=0.
- IDLE transitions:
  - Only m0_cyc set -> G0.
  - Only m1_cyc set -> G1.
  - Both set -> grant the master != last.
  - Neither set -> stay in IDLE.
  - Arbitration latency: one cycle from cyc to s_cyc.
- In Gx:
  - s_addr, s_wdata and s_we are driven from master x.
  - s_cyc = mx_cyc, combinational.
  - mx_ack = s_ack. The other master's ack is forced to 0.
- Outside a grant: s_cyc=0. s_addr, s_wdata and s_we follow master 0 (don't-care for the slave).
- Read data: s_rdata is broadcast to both m0_rdata and m1_rdata. It is only meaningful alongside that master's ack.
- End of grant on s_ack: next state = IDLE and last <= x.
- End of grant on abort: if mx_cyc drops in Gx without s_ack, s_cyc falls in the same cycle and next state = IDLE; `last` is unchanged.
- Spacing: IDLE always sits between two grants, so s_cyc is low for at least one cycle between transactions.
  - This lets slaves that ack on `cyc & ~ack_q` see a fresh cycle.
  - Back-to-back throughput per master is therefore one transaction per (slave latency + 2) cycles.
- Fairness: with both masters continuously requesting, grants strictly alternate 0,1,0,1...
- Simultaneous events:
  - s_ack in the same cycle mx_cyc drops: treated as completion, last updated.
  - A new request from the other master during Gx is held until IDLE.
- A spurious s_ack in IDLE is ignored; no master ack is produced.
- Reset mid-transaction: state returns to IDLE in the next cycle, s_cyc=0 immediately after that edge, and any pending ack is lost.

Optional Feature:
- Macro: WB_ARB_RR2_TIMEOUT_EN.
- Enabled:
  - A counter of width clog2(TIMEOUT+1) clears on grant entry and increments each Gx cycle without s_ack.
  - When it reaches TIMEOUT, in that cycle: mx_ack=1, mx_rdata forced to all ones, err=1 for one cycle, s_cyc=0.
  - Next state = IDLE and last <= x.
  - A real s_ack in the same cycle takes priority: normal completion, err=0.
- Disabled: no counter, err tied to 0, and a hung slave holds the grant indefinitely.

Test Plan:
- Single read: m0 read addr 0x012, slave acks 2 cycles after s_cyc with 0xCAFEF00D.
  -> s_cyc rises 1 cycle after m0_cyc; m0_ack pulses once with m0_rdata=0xCAFEF00D; m1_ack stays 0.
- Tie after reset: m0 and m1 raise cyc in the same cycle.
  -> m0 is served first, m1 in the following grant, with s_cyc low for ≥1 cycle between them.
- Continuous contention: both masters hold requests for 8 transactions.
  -> grant order is 0,1,0,1,0,1,0,1; s_addr matches the granted master each time.
- Abort: m1 granted, m1_cyc drops before any ack.
  -> s_cyc drops in the same cycle; pending m0 is granted 2 cycles later; last unchanged, so m0 still wins the next tie.
- wb_dma integration: wb_dma m1 port on master 0, CPU write stream on master 1, DMA length 4 M0->M1.
  -> 4 DMA writes complete with correct addresses and data, CPU writes interleaved, no lost or duplicated acks.
- Timeout (macro on, TIMEOUT=16): slave never acks.
  -> master ack and err both pulse at cycle 16 of the grant with rdata=0xFFFFFFFF, state returns to IDLE; without the macro, no ack ever arrives.
